// File: rtl/utopia_tx_scheduler_pkg.sv
// Shared types and constants for the Utopia transmit cell scheduler.
// Holds the FSM state encoding, the default cell length and the byte counter width.
// No logic here; imported by the interface and the scheduler top.
package utopia_tx_scheduler_pkg;

  // IDLE: waiting for an eligible port; XFER: cell bytes on the bus; GAP: one dead cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Bytes per ATM cell on an 8-bit Utopia bus
  localparam int CELL_BYTES = 53;

  // Width of the byte-within-cell counter (covers 0..63)
  localparam int BYTE_IDX_W = 6;

endpackage

// File: rtl/utopia_tx_scheduler_if.sv
// Bundle of request/cell-available inputs and cell-framing outputs of the scheduler.
// master = scheduler side (drives grant and framing), slave = PHY/requester side.
// Purely structural; no timing of its own.
interface utopia_tx_scheduler_if
  import utopia_tx_scheduler_pkg::*;
#(
  parameter int NUM_PORTS = 4
) ();

  localparam int SEL_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  clav;
  logic [NUM_PORTS-1:0]  grant;
  logic [SEL_W-1:0]      sel;
  logic [BYTE_IDX_W-1:0] byte_idx;
  logic                  soc;
  logic                  en;
  logic                  busy;
  logic                  cell_done;

  modport master (
    input  req, clav,
    output grant, sel, byte_idx, soc, en, busy, cell_done
  );

  modport slave (
    output req, clav,
    input  grant, sel, byte_idx, soc, en, busy, cell_done
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first eligible port scanning upward from rr_ptr, wrapping to 0.
// Purely combinational, zero latency.
// No backpressure; valid is low when nothing is eligible.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N-1:0]     winner,
  output logic             valid
);

  // Walk the ports in priority order starting at rr_ptr; the first hit wins
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && eligible[PTR_W'((int'(rr_ptr) + i) % N)]) begin
        winner[PTR_W'((int'(rr_ptr) + i) % N)] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/utopia_tx_scheduler.sv
// Utopia TX scheduler: round-robin picks a port with req&clav and frames one cell of CELL_BYTES bytes.
// Latency: eligibility sampled at edge t, byte 0 (soc) visible after edge t+1; one GAP cycle after each cell.
// A started cell always runs to completion; only reset aborts it. New cells start only while enable is high.
module utopia_tx_scheduler #(
  parameter int NUM_PORTS  = 4,
  parameter int CELL_BYTES = utopia_tx_scheduler_pkg::CELL_BYTES
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         enable,
  utopia_tx_scheduler_if.master        bus
);

  import utopia_tx_scheduler_pkg::*;

  localparam int SEL_W = $clog2(NUM_PORTS);
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX  = BYTE_IDX_W'(CELL_BYTES - 1);
  localparam logic [BYTE_IDX_W-1:0] ONE_B     = BYTE_IDX_W'(1);
  localparam logic [SEL_W-1:0]      LAST_PORT = SEL_W'(NUM_PORTS - 1);
  localparam logic [SEL_W-1:0]      ONE_P     = SEL_W'(1);

  state_t                state_q, state_d;
  logic [NUM_PORTS-1:0]  elig_q, elig_d;
  logic [NUM_PORTS-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic                  soc_q, soc_d;
  logic                  en_q, en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [NUM_PORTS-1:0]  win;
  logic                  win_vld;
  logic [SEL_W-1:0]      win_idx;

  // Sample the eligible set each cycle; enable gates it so a disabled scheduler sees nobody
  always_comb begin
    elig_d = enable ? (bus.req & bus.clav) : '0;
  end

  rr_arbiter #(
    .N     (NUM_PORTS),
    .PTR_W (SEL_W)
  ) u_rr_arbiter (
    .eligible (elig_q),
    .rr_ptr   (rr_ptr_q),
    .winner   (win),
    .valid    (win_vld)
  );

  // Encode the one-hot winner into the datapath mux select
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win[i]) win_idx = SEL_W'(i);
    end
  end

  // Next state and next registered outputs; idle values are the defaults
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = '0;
    sel_d      = '0;
    byte_idx_d = '0;
    soc_d      = 1'b0;
    en_d       = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d  = ST_XFER;
          grant_d  = win;
          sel_d    = win_idx;
          soc_d    = 1'b1;
          en_d     = 1'b0;
          busy_d   = 1'b1;
          done_d   = (LAST_IDX == '0);
          // The port just served drops to lowest priority next round
          rr_ptr_d = (win_idx == LAST_PORT) ? '0 : win_idx + ONE_P;
        end
      end
      ST_XFER: begin
        if (byte_idx_q == LAST_IDX) begin
          state_d = ST_GAP;
          busy_d  = 1'b1;
        end else begin
          grant_d    = grant_q;
          sel_d      = sel_q;
          byte_idx_d = byte_idx_q + ONE_B;
          en_d       = 1'b0;
          busy_d     = 1'b1;
          done_d     = ((byte_idx_q + ONE_B) == LAST_IDX);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any cell in flight
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      elig_q     <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      sel_q      <= '0;
      byte_idx_q <= '0;
      soc_q      <= 1'b0;
      en_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      elig_q     <= elig_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      byte_idx_q <= byte_idx_d;
      soc_q      <= soc_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.byte_idx  = byte_idx_q;
  assign bus.soc       = soc_q;
  assign bus.en        = en_q;
  assign bus.busy      = busy_q;
  assign bus.cell_done = done_q;

endmodule

// File: tb/tb_utopia_tx_scheduler.sv
// Self-checking bench for utopia_tx_scheduler: vector table plus scoreboarded cell monitor.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
// Every check is bounded so the run always reaches its summary line.
module tb_utopia_tx_scheduler;

  localparam int NP   = 4;
  localparam int CB   = 53;
  localparam int LAST = CB - 1;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  logic enable = 1'b0;

  utopia_tx_scheduler_if #(.NUM_PORTS(NP)) bus ();

  utopia_tx_scheduler #(
    .NUM_PORTS  (NP),
    .CELL_BYTES (CB)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic void chk(bit ok, string name, longint act, longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Scoreboard: expected port index of each upcoming cell, in order
  int exp_q[$];

  // Monitor state
  logic           rst_smp;
  bit             in_cell       = 1'b0;
  bit             exp_gap       = 1'b0;
  bit             chk_spacing   = 1'b0;
  int             exp_byte      = 0;
  logic [NP-1:0]  cur_grant     = '0;
  logic [1:0]     cur_sel       = '0;
  int             last_done_cyc = -1;
  int             last_soc_cyc  = -1;
  int             n_soc         = 0;
  int             n_done        = 0;

  // Cell monitor: frames every cell independently of the DUT and compares each cycle
  initial begin
    forever begin
      @(posedge clk_in);
      rst_smp = reset;
      cyc++;
      @(negedge clk_in);
      if (!rst_smp) begin
        chk({bus.grant, bus.sel, bus.byte_idx, bus.soc, bus.en, bus.busy, bus.cell_done} ==
            {4'b0, 2'b0, 6'b0, 1'b0, 1'b1, 1'b0, 1'b0}, "reset_values",
            {bus.grant, bus.sel, bus.byte_idx, bus.soc, bus.en, bus.busy, bus.cell_done},
            {4'b0, 2'b0, 6'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        in_cell       = 1'b0;
        exp_gap       = 1'b0;
        last_done_cyc = -1;
      end else begin
        chk($onehot0(bus.grant), "grant_onehot", bus.grant, 0);
        if (exp_gap) begin
          chk({bus.grant, bus.en, bus.soc, bus.busy, bus.cell_done} == {4'b0, 1'b1, 1'b0, 1'b1, 1'b0},
              "gap_cycle", {bus.grant, bus.en, bus.soc, bus.busy, bus.cell_done},
              {4'b0, 1'b1, 1'b0, 1'b1, 1'b0});
          exp_gap = 1'b0;
        end else if (in_cell || bus.soc) begin
          if (!in_cell) begin
            n_soc++;
            last_soc_cyc = cyc;
            if (exp_q.size() == 0) begin
              chk(1'b0, "unexpected_cell", bus.grant, 0);
              cur_grant = bus.grant;
              cur_sel   = bus.sel;
            end else begin
              int p;
              p = exp_q.pop_front();
              cur_grant = NP'(1) << p;
              cur_sel   = 2'(p);
              chk(bus.grant == cur_grant, "cell_grant", bus.grant, cur_grant);
              chk(bus.sel == cur_sel, "cell_sel", bus.sel, cur_sel);
            end
            if (chk_spacing && last_done_cyc >= 0)
              chk(cyc - last_done_cyc == 3, "b2b_spacing", cyc - last_done_cyc, 3);
            in_cell  = 1'b1;
            exp_byte = 0;
          end
          chk(int'(bus.byte_idx) == exp_byte, "byte_idx", bus.byte_idx, exp_byte);
          chk({bus.soc, bus.en, bus.busy, bus.cell_done} ==
              {(exp_byte == 0), 1'b0, 1'b1, (exp_byte == LAST)}, "cell_ctrl",
              {bus.soc, bus.en, bus.busy, bus.cell_done},
              {(exp_byte == 0), 1'b0, 1'b1, (exp_byte == LAST)});
          chk(bus.grant == cur_grant && bus.sel == cur_sel, "grant_held",
              {bus.grant, bus.sel}, {cur_grant, cur_sel});
          if (exp_byte == LAST) begin
            n_done++;
            in_cell       = 1'b0;
            exp_gap       = 1'b1;
            last_done_cyc = cyc;
          end else begin
            exp_byte++;
          end
        end else begin
          chk({bus.grant, bus.sel, bus.en, bus.busy, bus.cell_done} == {4'b0, 2'b0, 1'b1, 1'b0, 1'b0},
              "idle_cycle", {bus.grant, bus.sel, bus.en, bus.busy, bus.cell_done},
              {4'b0, 2'b0, 1'b1, 1'b0, 1'b0});
        end
      end
    end
  end

  task automatic drive(input logic [NP-1:0] r, input logic [NP-1:0] c, input logic e);
    @(posedge clk_in);
    #1;
    bus.req  = r;
    bus.clav = c;
    enable   = e;
  endtask

  task automatic do_reset();
    @(posedge clk_in);
    #1;
    reset    = 1'b0;
    bus.req  = '0;
    bus.clav = '0;
    enable   = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_soc(input int target, input int budget);
    int i;
    i = 0;
    while (n_soc < target && i < budget) begin
      @(negedge clk_in);
      #1;
      i++;
    end
    chk(n_soc >= target, "wait_soc_timeout", n_soc, target);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || in_cell || exp_gap) && i < budget) begin
      @(negedge clk_in);
      #1;
      i++;
    end
    chk(exp_q.size() == 0 && !in_cell && !exp_gap, "wait_idle_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_byte(input int b, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk_in);
      hit = bus.busy && (int'(bus.byte_idx) == b);
    end
    chk(hit, "wait_byte_timeout", bus.byte_idx, b);
  endtask

  typedef struct {
    logic [NP-1:0]   req;
    logic [NP-1:0]   clav;
    logic            enable;
    int              ncells;
    logic [4:0][1:0] ports;
    bit              spacing;
    string           name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int base;
    int done_before;
    int drv_cyc;

    bus.req  = '0;
    bus.clav = '0;

    vecs[0] = '{4'b0001, 4'b0001, 1'b1, 1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 1'b0, "single_port0"};
    vecs[1] = '{4'b1111, 4'b1111, 1'b1, 5, {2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, 1'b1, "all_rr_order"};
    vecs[2] = '{4'b0110, 4'b0010, 1'b1, 1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd1}, 1'b0, "clav_masks_p2"};
    vecs[3] = '{4'b0001, 4'b0001, 1'b1, 2, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 1'b1, "single_b2b"};
    vecs[4] = '{4'b1111, 4'b1111, 1'b0, 0, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 1'b0, "disabled"};
    vecs[5] = '{4'b1000, 4'b1000, 1'b1, 1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd3}, 1'b0, "port3_only"};
    vecs[6] = '{4'b0101, 4'b1100, 1'b1, 1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd2}, 1'b0, "overlap_p2"};
    vecs[7] = '{4'b1111, 4'b0000, 1'b1, 0, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 1'b0, "no_clav"};

    // Table-driven vectors, each from a fresh reset so arbitration starts at port 0
    for (int v = 0; v < 8; v++) begin
      do_reset();
      chk_spacing = vecs[v].spacing;
      for (int c = 0; c < vecs[v].ncells; c++) exp_q.push_back(int'(vecs[v].ports[c]));
      base = n_soc;
      drive(vecs[v].req, vecs[v].clav, vecs[v].enable);
      if (vecs[v].ncells > 0) begin
        wait_soc(base + vecs[v].ncells, 70 * vecs[v].ncells + 20);
        drive('0, '0, vecs[v].enable);
        wait_idle(200);
      end else begin
        repeat (100) @(negedge clk_in);
        chk(bus.busy == 1'b0 && bus.grant == '0 && n_soc == base, {vecs[v].name, "_stays_idle"},
            n_soc - base, 0);
      end
      chk_spacing = 1'b0;
    end

    // Latency: requests sampled at edge t show byte 0 after edge t+1
    do_reset();
    repeat (4) @(posedge clk_in);
    exp_q.push_back(0);
    base = n_soc;
    drive(4'b0001, 4'b0001, 1'b1);
    drv_cyc = cyc;
    wait_soc(base + 1, 20);
    chk(last_soc_cyc - drv_cyc == 2, "start_latency", last_soc_cyc - drv_cyc, 2);
    drive('0, '0, 1'b1);
    wait_idle(100);

    // Pointer moves past the served port: port 1, then port 2 once its clav appears
    do_reset();
    exp_q.push_back(1);
    base = n_soc;
    drive(4'b0110, 4'b0010, 1'b1);
    wait_soc(base + 1, 30);
    exp_q.push_back(2);
    drive(4'b0110, 4'b0110, 1'b1);
    wait_soc(base + 2, 100);
    drive('0, '0, 1'b1);
    wait_idle(100);

    // req and clav drop mid-cell: the cell still completes, then idle
    do_reset();
    exp_q.push_back(0);
    done_before = n_done;
    drive(4'b0001, 4'b0001, 1'b1);
    wait_byte(20, 40);
    drive('0, '0, 1'b1);
    wait_idle(100);
    repeat (5) @(negedge clk_in);
    chk(n_done == done_before + 1, "drop_req_completes", n_done - done_before, 1);

    // enable drops mid-cell with req held: cell completes, no further cells start
    do_reset();
    exp_q.push_back(2);
    base = n_soc;
    drive(4'b0100, 4'b0100, 1'b1);
    wait_byte(10, 40);
    drive(4'b0100, 4'b0100, 1'b0);
    wait_idle(100);
    repeat (30) @(negedge clk_in);
    chk(n_soc == base + 1 && bus.busy == 1'b0, "disable_midcell", n_soc - base, 1);
    drive('0, '0, 1'b0);

    // Reset mid-cell aborts without cell_done; first grant afterwards honours port 3
    do_reset();
    exp_q.push_back(0);
    drive(4'b0001, 4'b0001, 1'b1);
    wait_byte(30, 50);
    done_before = n_done;
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    chk(n_done == done_before && bus.cell_done == 1'b0, "abort_no_done", n_done - done_before, 0);
    exp_q.push_back(3);
    base = n_soc;
    bus.req  = 4'b1000;
    bus.clav = 4'b1000;
    reset    = 1'b1;
    wait_soc(base + 1, 20);
    drive('0, '0, 1'b1);
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/utopia_tx_scheduler.md
UTOPIA_TX_SCHEDULER -- requirements
Module: utopia_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of transmit requesters/PHY ports (2..8).
REQ-002 SHALL have parameter CELL_BYTES, default 53, bytes per ATM cell on an 8-bit Utopia bus.
REQ-003 SHALL use a single clock and a synchronous, active-low reset, as below.
REQ-004 clk_in  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 enable  input  1  scheduler may start new cells when high.
REQ-007 req  input  NUM_PORTS  per-port "cell ready to send".
REQ-008 clav  input  NUM_PORTS  per-port PHY cell-available (space for one cell).
REQ-009 grant  output  NUM_PORTS  one-hot owner of current cell; zero when idle.
REQ-010 sel  output  clog2(NUM_PORTS)  binary index of granted port (datapath mux select).
REQ-011 byte_idx  output  6  byte number within current cell, 0..CELL_BYTES-1.
REQ-012 soc  output  1  start-of-cell, high on byte 0 only.
REQ-013 en  output  1  Utopia transmit enable, active low; low on every cell byte.
REQ-014 busy  output  1  high while a cell transfer or gap is in progress.
REQ-015 cell_done  output  1  one-cycle pulse on the last byte of a cell.

Function
REQ-016 SHALL implement FSM states IDLE, XFER, GAP; all outputs registered.
REQ-017 Port i eligible when req[i] & clav[i]; IDLE -> XFER when enable & any eligible.
REQ-018 Winner = first eligible port scanning from rr_ptr upward with wrap at NUM_PORTS-1 -> 0.
REQ-019 Latency: eligibility sampled in IDLE at edge t; byte 0 (soc=1, en=0, grant/sel valid, byte_idx=0) visible after edge t+1.
REQ-020 In XFER byte_idx SHALL increment by 1 per cycle; grant/sel held constant for all CELL_BYTES cycles.
REQ-021 cell_done=1 exactly when byte_idx=CELL_BYTES-1; next state GAP.
REQ-022 GAP lasts exactly one cycle: grant=0, en=1, soc=0, busy=1; then IDLE.
REQ-023 On entering XFER for port i, rr_ptr SHALL become (i+1) mod NUM_PORTS.
REQ-024 req, clav or enable deasserting mid-cell SHALL NOT truncate the cell; cell always completes.
REQ-025 No eligible port or enable=0 in IDLE: remain IDLE, rr_ptr unchanged.
REQ-026 Single eligible port requesting continuously SHALL receive back-to-back cells spaced by one GAP cycle plus one IDLE cycle.
REQ-027 grant SHALL never have more than one bit set; sel SHALL equal index of set grant bit (0 when idle).

Reset
REQ-028 reset=0 at a rising edge: state=IDLE, rr_ptr=0, grant=0, sel=0, byte_idx=0, soc=0, en=1, busy=0, cell_done=0.
REQ-029 reset asserted mid-cell SHALL abort the cell immediately; no cell_done pulse for the aborted cell.
REQ-030 First arbitration after reset release SHALL start scanning at port 0.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, CELL_BYTES constant (53) and byte-index width (6).
REQ-032 Round-robin priority picker SHALL be a separate sub-module rr_arbiter (inputs eligible vector and rr_ptr; outputs one-hot winner and valid).
REQ-033 Estimated size 150-250 lines RTL including rr_arbiter.

Verification
REQ-034 req=clav=4'b0001, enable=1 -> grant=0001, sel=0, soc on byte 0, en low 53 cycles, cell_done on byte_idx=52, one GAP cycle.
REQ-035 req=clav=4'b1111 held -> grants in order port 0,1,2,3,0, each 53 bytes, each separated by GAP+IDLE.
REQ-036 req=4'b0110, clav=4'b0010 -> only port 1 granted; then clav=4'b0110 -> port 2 next (rr_ptr=2).
REQ-037 clav and req drop to 0 at byte_idx=20 -> cell continues to byte 52, cell_done pulses, then IDLE.
REQ-038 reset=0 at byte_idx=30 -> next cycle all outputs at reset values, no cell_done; after release with req=clav=4'b1000 -> grant=1000.
REQ-039 enable=0 with req=clav=4'b1111 -> stays IDLE, grant=0, busy=0 indefinitely.
